// File: rtl/program_counter_reg.sv
// Architectural program-counter register for the single-cycle RV32I core.
// Optional macro PC_ALIGN_CHECK_EN: force 4-byte alignment and flag misaligned targets.
module program_counter_reg #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC_Next,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_Plus4
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic            PC_Misaligned
`endif
);

  logic [XLEN-1:0] pc_load;

  // Value actually captured at the edge; alignment drops the two byte-offset bits.
  always_comb begin
`ifdef PC_ALIGN_CHECK_EN
    pc_load = {PC_Next[XLEN-1:2], 2'b00};
`else
    pc_load = PC_Next;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC <= RESET_VECTOR;
    end else begin
      PC <= pc_load;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_Misaligned <= 1'b0;
    end else begin
      PC_Misaligned <= (PC_Next[1:0] != 2'b00);
    end
  end
`endif

  // Carry out of the top bit is discarded, so the address wraps.
  assign PC_Plus4 = PC + XLEN'(4);

endmodule

// File: tb/tb_program_counter_reg.sv
// Self-checking bench for program_counter_reg: per-cycle model comparison plus
// directed literal checks; define PC_ALIGN_CHECK_EN to exercise alignment.
module tb_program_counter_reg;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] PC_Next;
  logic [31:0] PC;
  logic [31:0] PC_Plus4;
`ifdef PC_ALIGN_CHECK_EN
  logic        PC_Misaligned;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  program_counter_reg #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk          (clk),
    .rst          (rst),
    .PC_Next      (PC_Next),
    .PC           (PC),
    .PC_Plus4     (PC_Plus4)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .PC_Misaligned(PC_Misaligned)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected target address taken from a requested next-PC.
  function automatic logic [31:0] target(input logic [31:0] n);
`ifdef PC_ALIGN_CHECK_EN
    return n & ~32'h3;
`else
    return n;
`endif
  endfunction

  function automatic logic [31:0] plus4(input logic [31:0] p);
    return 32'((64'(p) + 64'd4) % 64'h1_0000_0000);
  endfunction

  // Model: what was presented at the most recent rising edge.
  logic        samp_rst  = 1'b1;
  logic [31:0] samp_next = '0;
  always @(posedge clk) begin
    samp_rst  = rst;
    samp_next = PC_Next;
  end

  // Compare process, half a cycle after each edge.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    exp_pc = (rst || samp_rst) ? RV : target(samp_next);
    check("pc_model", PC, exp_pc);
    check("plus4_model", PC_Plus4, plus4(exp_pc));
`ifdef PC_ALIGN_CHECK_EN
    check("misaligned_model", 32'(PC_Misaligned),
          32'((!rst && !samp_rst && samp_next[1:0] != 2'b00) ? 1 : 0));
`endif
  end

  task automatic next_cycle();
    @(posedge clk);
    #5;
  endtask

  initial begin
    rst     = 1'b1;
    PC_Next = 32'h0;

    // Reset across one edge.
    next_cycle();
    check("reset_pc", PC, 32'h0);
    check("reset_plus4", PC_Plus4, 32'h4);
    rst     = 1'b0;
    PC_Next = 32'h4;

    // Sequential fetch.
    for (int a = 8; a <= 32; a += 4) begin
      next_cycle();
      PC_Next = 32'(a);
    end
    next_cycle();
    check("seq_final_pc", PC, 32'h20);
    check("seq_final_plus4", PC_Plus4, 32'h24);

    // Async reset mid-cycle.
    PC_Next = 32'h10;
    next_cycle();
    check("pre_reset_pc", PC, 32'h10);
    PC_Next = 32'h40;
    #3 rst = 1'b1;
    #1 check("async_reset_pc", PC, 32'h0);
    check("async_reset_plus4", PC_Plus4, 32'h4);
    next_cycle();
    check("reset_hold1_pc", PC, 32'h0);
    next_cycle();
    check("reset_hold2_pc", PC, 32'h0);
    rst = 1'b0;
    next_cycle();
    check("post_reset_pc", PC, 32'h40);

    // Jump to top of address space, wrap of PC+4.
    PC_Next = 32'hFFFF_FFFC;
    next_cycle();
    check("wrap_pc", PC, 32'hFFFF_FFFC);
    check("wrap_plus4", PC_Plus4, 32'h0);
    PC_Next = 32'h100;
    next_cycle();
    check("jump_pc", PC, 32'h100);

    // Changes between edges are ignored.
    PC_Next = 32'h44;
    next_cycle();
    check("hold_a_pc", PC, 32'h44);
    #3 PC_Next = 32'h48;
    #1 check("hold_mid_pc", PC, 32'h44);
    next_cycle();
    check("hold_b_pc", PC, 32'h48);

    // All-ones target.
    PC_Next = 32'hFFFF_FFFF;
    next_cycle();
`ifdef PC_ALIGN_CHECK_EN
    check("ones_pc", PC, 32'hFFFF_FFFC);
    check("ones_misaligned", 32'(PC_Misaligned), 32'h1);
`else
    check("ones_pc", PC, 32'hFFFF_FFFF);
    check("ones_plus4", PC_Plus4, 32'h3);
`endif

`ifdef PC_ALIGN_CHECK_EN
    PC_Next = 32'h102;
    next_cycle();
    check("align_pc", PC, 32'h100);
    check("align_misaligned", 32'(PC_Misaligned), 32'h1);
    PC_Next = 32'h104;
    next_cycle();
    check("align_ok_pc", PC, 32'h104);
    check("align_ok_misaligned", 32'(PC_Misaligned), 32'h0);
`endif

    PC_Next = 32'h200;
    next_cycle();
    next_cycle();
    check("final_pc", PC, 32'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
